// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared types and default sizes for partial-sum accumulation
package psum_pkg;

  localparam int CHANNEL_NUM    = 128;
  localparam int PSUM_WIDTH     = 16;
  localparam int ACC_WIDTH      = 20;
  localparam int TILE_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } psum_state_e;

endpackage

// File: rtl/psum_acc_lane.sv
// rtl/psum_acc_lane.sv - one channel's signed accumulator with clear and enable
module psum_acc_lane #(
  parameter int PSUM_WIDTH = psum_pkg::PSUM_WIDTH,
  parameter int ACC_WIDTH  = psum_pkg::ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PSUM_WIDTH-1:0] psum,
  output logic [ACC_WIDTH-1:0]  acc
);
  import psum_pkg::*;

  logic [ACC_WIDTH-1:0] psum_ext;

  assign psum_ext = {{(ACC_WIDTH-PSUM_WIDTH){psum[PSUM_WIDTH-1]}}, psum};

  // Sum wraps modulo 2^ACC_WIDTH by construction of the register width.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + psum_ext;
    end
  end

endmodule

// File: rtl/psum_accum_ctrl.sv
// rtl/psum_accum_ctrl.sv - sequences per-layer multi-tile partial-sum accumulation
module psum_accum_ctrl #(
  parameter int CHANNEL_NUM    = psum_pkg::CHANNEL_NUM,
  parameter int PSUM_WIDTH     = psum_pkg::PSUM_WIDTH,
  parameter int ACC_WIDTH      = psum_pkg::ACC_WIDTH,
  parameter int TILE_CNT_WIDTH = psum_pkg::TILE_CNT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [TILE_CNT_WIDTH-1:0]         num_tiles,
  input  logic                              psum_valid,
  output logic                              psum_ready,
  input  logic [CHANNEL_NUM*PSUM_WIDTH-1:0] psum_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CHANNEL_NUM*ACC_WIDTH-1:0]  acc_out,
  output logic                              busy,
  output logic [TILE_CNT_WIDTH-1:0]         tile_idx,
  output logic                              done
);
  import psum_pkg::*;

  psum_state_e               state;
  psum_state_e               state_nxt;
  logic [TILE_CNT_WIDTH-1:0] num_q;
  logic [TILE_CNT_WIDTH-1:0] tile_q;
  logic                      start_ok;
  logic                      accept;
  logic                      last_beat;
  logic                      done_q;

  assign start_ok  = (state == IDLE) && start;
  assign accept    = psum_valid && psum_ready;
  assign last_beat = accept && (tile_q == (num_q - TILE_CNT_WIDTH'(1)));
  assign tile_idx  = tile_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = ACCUM;
      ACCUM:   if (last_beat) state_nxt = OUTPUT;
      OUTPUT:  if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psum_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ACCUM: begin
        psum_ready = 1'b1;
        busy       = 1'b1;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // A programmed count of zero runs a single tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q  <= '0;
      tile_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= out_valid && out_ready;
      if (start_ok) begin
        num_q  <= (num_tiles == '0) ? TILE_CNT_WIDTH'(1) : num_tiles;
        tile_q <= '0;
      end else if (accept) begin
        tile_q <= tile_q + TILE_CNT_WIDTH'(1);
      end
    end
  end

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_lane
    psum_acc_lane #(
      .PSUM_WIDTH (PSUM_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_ok),
      .en   (accept),
      .psum (psum_in[c*PSUM_WIDTH +: PSUM_WIDTH]),
      .acc  (acc_out[c*ACC_WIDTH +: ACC_WIDTH])
    );
  end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// tb/tb_psum_accum_ctrl.sv - randomized self-checking bench for psum_accum_ctrl
module tb_psum_accum_ctrl;
  localparam int CN = 128;
  localparam int PW = 16;
  localparam int AW = 20;
  localparam int TW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [TW-1:0]    num_tiles;
  logic             psum_valid;
  logic             psum_ready;
  logic [CN*PW-1:0] psum_in;
  logic             out_valid;
  logic             out_ready;
  logic [CN*AW-1:0] acc_out;
  logic             busy;
  logic [TW-1:0]    tile_idx;
  logic             done;

  int checks = 0;
  int errors = 0;
  int model[CN];
  int beat[CN];

  always #5 clk = ~clk;

  psum_accum_ctrl #(
    .CHANNEL_NUM    (CN),
    .PSUM_WIDTH     (PW),
    .ACC_WIDTH      (AW),
    .TILE_CNT_WIDTH (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_tiles  (num_tiles),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_in    (psum_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .busy       (busy),
    .tile_idx   (tile_idx),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int c = 0; c < CN; c++) model[c] = 0;
  endtask

  task automatic model_accept();
    for (int c = 0; c < CN; c++) model[c] = model[c] + beat[c];
  endtask

  task automatic set_ch(input int c, input int v);
    beat[c] = v;
    psum_in[c*PW +: PW] = v[PW-1:0];
  endtask

  task automatic drive_beat(input bit fill, input int val);
    for (int c = 0; c < CN; c++)
      set_ch(c, fill ? val : (int'($urandom_range(0, 65535)) - 32768));
  endtask

  function automatic int first_bad_ch();
    int m;
    logic [AW-1:0] e;
    for (int c = 0; c < CN; c++) begin
      m = model[c];
      e = m[AW-1:0];
      if (acc_out[c*AW +: AW] !== e) return c;
    end
    return -1;
  endfunction

  task automatic do_start(input int n);
    start = 1'b1;
    num_tiles = TW'(n);
    tick();
    start = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    int b;
    rst = 1'b1;
    start = 1'($urandom);
    num_tiles = TW'($urandom);
    psum_valid = 1'($urandom);
    out_ready = 1'($urandom);
    drive_beat(1'b0, 0);
    tick();
    tick();
    checks++; if (psum_ready !== 1'b0) begin errors++; $display("FAIL reset_psum_ready got %b exp 0", psum_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (tile_idx !== '0) begin errors++; $display("FAIL reset_tile_idx got %0d exp 0", tile_idx); end
    model_clear();
    b = first_bad_ch();
    checks++; if (b >= 0) begin errors++; $display("FAIL reset_acc ch%0d got %h exp 0", b, acc_out[b*AW +: AW]); end
    rst = 1'b0;
    start = 1'b0;
    psum_valid = 1'b0;
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int seq0[3];
    int b;
    seq0 = '{5, -3, 7};
    do_start(3);
    checks++; if (psum_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_enter ready=%b busy=%b exp 1 1", psum_ready, busy); end
    for (int i = 0; i < 3; i++) begin
      drive_beat(1'b0, 0);
      set_ch(0, seq0[i]);
      set_ch(127, 1);
      psum_valid = 1'b1;
      tick();
      model_accept();
      checks++; if (out_valid !== (i == 2)) begin errors++; $display("FAIL basic_out_valid beat%0d got %b exp %b", i, out_valid, (i == 2)); end
    end
    psum_valid = 1'b0;
    checks++; if (acc_out[AW-1:0] !== 20'd9) begin errors++; $display("FAIL basic_ch0 got %0d exp 9", acc_out[AW-1:0]); end
    checks++; if (acc_out[127*AW +: AW] !== 20'd3) begin errors++; $display("FAIL basic_ch127 got %0d exp 3", acc_out[127*AW +: AW]); end
    b = first_bad_ch();
    checks++; if (b >= 0) begin errors++; $display("FAIL basic_acc ch%0d got %h exp %h", b, acc_out[b*AW +: AW], model[b]); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_handshake done=%b busy=%b out_valid=%b exp 1 0 0", done, busy, out_valid); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", done); end
  endtask

  task automatic test_backpressure();
    bit pat[4];
    int exp_idx;
    int dones;
    int b;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_idx = 0;
    do_start(2);
    for (int i = 0; i < 4; i++) begin
      drive_beat(1'b0, 0);
      psum_valid = pat[i];
      tick();
      if (pat[i]) begin model_accept(); exp_idx++; end
      checks++; if (tile_idx !== TW'(exp_idx)) begin errors++; $display("FAIL bp_tile_idx cyc%0d got %0d exp %0d", i, tile_idx, exp_idx); end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b exp 1", out_valid); end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(1'b0, 0);
      psum_valid = 1'b1;
      tick();
      if (done) dones++;
      b = first_bad_ch();
      checks++; if (b >= 0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable cyc%0d ch%0d out_valid=%b exp 1", i, b, out_valid); end
    end
    psum_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (done) dones++;
    tick();
    if (done) dones++;
    checks++; if (dones !== 1) begin errors++; $display("FAIL bp_done_pulses got %0d exp 1", dones); end
  endtask

  task automatic test_zero_count();
    int b;
    do_start(0);
    drive_beat(1'b1, -1);
    psum_valid = 1'b1;
    tick();
    model_accept();
    psum_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || tile_idx !== TW'(1)) begin errors++; $display("FAIL zero_count out_valid=%b tile_idx=%0d exp 1 1", out_valid, tile_idx); end
    checks++; if (acc_out[5*AW +: AW] !== 20'hFFFFF) begin errors++; $display("FAIL zero_ch5 got %h exp fffff", acc_out[5*AW +: AW]); end
    b = first_bad_ch();
    checks++; if (b >= 0) begin errors++; $display("FAIL zero_acc ch%0d got %h exp fffff", b, acc_out[b*AW +: AW]); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_ignore_abort();
    int b;
    do_start(4);
    drive_beat(1'b0, 0);
    psum_valid = 1'b1;
    tick();
    model_accept();
    start = 1'b1;
    num_tiles = TW'(1);
    drive_beat(1'b0, 0);
    tick();
    model_accept();
    start = 1'b0;
    checks++; if (tile_idx !== TW'(2) || psum_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ignore_start tile_idx=%0d ready=%b out_valid=%b exp 2 1 0", tile_idx, psum_ready, out_valid); end
    b = first_bad_ch();
    checks++; if (b >= 0) begin errors++; $display("FAIL ignore_acc ch%0d got %h exp %h", b, acc_out[b*AW +: AW], model[b]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    psum_valid = 1'b0;
    model_clear();
    b = first_bad_ch();
    checks++; if (busy !== 1'b0 || psum_ready !== 1'b0 || tile_idx !== '0 || b >= 0) begin errors++; $display("FAIL abort busy=%b ready=%b tile_idx=%0d badch=%0d exp 0 0 0 -1", busy, psum_ready, tile_idx, b); end
    do_start(1);
    drive_beat(1'b1, 100);
    psum_valid = 1'b1;
    tick();
    model_accept();
    psum_valid = 1'b0;
    b = first_bad_ch();
    checks++; if (out_valid !== 1'b1 || b >= 0) begin errors++; $display("FAIL restart out_valid=%b badch=%0d exp 1 -1", out_valid, b); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_extremes();
    int b;
    do_start(15);
    for (int i = 0; i < 15; i++) begin
      drive_beat(1'b1, -32768);
      psum_valid = 1'b1;
      tick();
      model_accept();
      checks++; if (out_valid !== (i == 14)) begin errors++; $display("FAIL ext_out_valid beat%0d got %b exp %b", i, out_valid, (i == 14)); end
    end
    psum_valid = 1'b0;
    checks++; if (acc_out[AW-1:0] !== 20'h88000) begin errors++; $display("FAIL ext_ch0 got %h exp 88000", acc_out[AW-1:0]); end
    b = first_bad_ch();
    checks++; if (b >= 0) begin errors++; $display("FAIL ext_acc ch%0d got %h exp 88000", b, acc_out[b*AW +: AW]); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random_runs();
    int n, eff, got, cyc, b;
    bit v;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 15);
      eff = (n == 0) ? 1 : n;
      do_start(n);
      got = 0;
      cyc = 0;
      while (got < eff && cyc < 200) begin
        v = ($urandom_range(0, 9) < 7);
        drive_beat(1'b0, 0);
        psum_valid = v;
        tick();
        if (v) begin model_accept(); got++; end
        cyc++;
      end
      psum_valid = 1'b0;
      checks++; if (got !== eff) begin errors++; $display("FAIL rand_budget run%0d got %0d beats exp %0d", r, got, eff); end
      checks++; if (out_valid !== 1'b1 || tile_idx !== TW'(eff)) begin errors++; $display("FAIL rand_end run%0d out_valid=%b tile_idx=%0d exp 1 %0d", r, out_valid, tile_idx, eff); end
      b = first_bad_ch();
      checks++; if (b >= 0) begin errors++; $display("FAIL rand_acc run%0d ch%0d got %h exp %h", r, b, acc_out[b*AW +: AW], model[b]); end
      repeat ($urandom_range(0, 3)) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rand_done run%0d done=%b out_valid=%b exp 1 0", r, done, out_valid); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_tiles = '0;
    psum_valid = 1'b0;
    out_ready = 1'b0;
    psum_in = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_ignore_abort();
    test_extremes();
    test_random_runs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
